// File: rtl/flappy_pkg.sv
// Shared phase encoding and timing defaults for the Flappy game-phase sequencer.
package flappy_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    READY   = 3'd1,
    RUNNING = 3'd2,
    PAUSED  = 3'd3,
    OVER    = 3'd4
  } game_phase_t;

  localparam int unsigned SEC_CYCLES_DEFAULT = 25_000_000;

  // Phases in which the game clock advances.
  function automatic logic phase_active(input game_phase_t ph);
    return (ph == READY) || (ph == RUNNING);
  endfunction

endpackage

// File: rtl/sec_prescaler.sv
// Modulus prescaler for the game-second timebase: counts while run is high,
// holds otherwise, and flags the cycle in which the count sits at MOD-1.
module sec_prescaler #(
  parameter int unsigned MOD = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(MOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MOD - 1);

  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             tick_r;

  // Next count: clear wins, wrap after LAST, hold when not running.
  always_comb begin
    count_nxt_s = count_r;
    if (clear) begin
      count_nxt_s = CNT_W'(0);
    end else if (run) begin
      if (count_r == LAST) begin
        count_nxt_s = CNT_W'(0);
      end else begin
        count_nxt_s = count_r + CNT_W'(1);
      end
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Tick is registered from the next count so it coincides with count==LAST.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= CNT_W'(0);
      tick_r  <= 1'b0;
    end else begin
      count_r <= count_nxt_s;
      tick_r  <= run && (count_nxt_s == LAST);
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/game_timer_ctrl.sv
// Flappy game-phase sequencer: READY countdown, RUNNING/PAUSED play gating and
// elapsed-seconds score. Define BEST_SCORE_EN to keep a best-score register.
module game_timer_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned CLK_PER_SEC = SEC_CYCLES_DEFAULT,
  parameter int unsigned SEC_W       = 16,
  parameter int unsigned GRACE_SEC   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_req,
  input  logic             pause_req,
  input  logic             collision,
  output logic [2:0]       state,
  output logic             play_en,
  output logic             sec_tick,
  output logic [1:0]       countdown,
  output logic [SEC_W-1:0] elapsed_sec,
  output logic [SEC_W-1:0] best_sec,
  output logic             new_best
);

  localparam logic [1:0]       GRACE       = 2'(GRACE_SEC);
  localparam logic [SEC_W-1:0] SEC_MAX     = {SEC_W{1'b1}};
  localparam game_phase_t      START_PHASE = (GRACE_SEC == 0) ? RUNNING : READY;

  game_phase_t      state_r, state_nxt_s;
  logic [1:0]       countdown_r, countdown_nxt_s;
  logic [SEC_W-1:0] elapsed_r, elapsed_nxt_s;
  logic             play_en_r;
  logic             tick_s;
  logic             start_s;

  assign start_s = start_req && ((state_r == IDLE) || (state_r == OVER));

  // Prescaler runs in the cycles whose phase is READY/RUNNING; restarts zero it.
  sec_prescaler #(.MOD(CLK_PER_SEC)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .run   (phase_active(state_nxt_s)),
    .clear (start_s),
    .tick  (tick_s)
  );

  // Phase transitions; collision outranks pause in RUNNING.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE, OVER: begin
        if (start_req) state_nxt_s = START_PHASE;
        else           state_nxt_s = state_r;
      end
      READY: begin
        if (tick_s && (countdown_r == 2'd1)) state_nxt_s = RUNNING;
        else                                 state_nxt_s = state_r;
      end
      RUNNING: begin
        if (collision)      state_nxt_s = OVER;
        else if (pause_req) state_nxt_s = PAUSED;
        else                state_nxt_s = state_r;
      end
      PAUSED: begin
        if (pause_req) state_nxt_s = RUNNING;
        else           state_nxt_s = state_r;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Countdown and saturating score; a tick landing with a collision still counts.
  always_comb begin
    countdown_nxt_s = countdown_r;
    elapsed_nxt_s   = elapsed_r;
    if (start_s) begin
      countdown_nxt_s = GRACE;
      elapsed_nxt_s   = {SEC_W{1'b0}};
    end else if (tick_s && (state_r == READY)) begin
      countdown_nxt_s = countdown_r - 2'd1;
    end else if (tick_s && (state_r == RUNNING) && (elapsed_r != SEC_MAX)) begin
      elapsed_nxt_s = elapsed_r + SEC_W'(1);
    end else begin
      countdown_nxt_s = countdown_r;
      elapsed_nxt_s   = elapsed_r;
    end
  end

  // Phase, play gate, countdown and score registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      play_en_r   <= 1'b0;
      countdown_r <= 2'd0;
      elapsed_r   <= {SEC_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      play_en_r   <= (state_nxt_s == RUNNING);
      countdown_r <= countdown_nxt_s;
      elapsed_r   <= elapsed_nxt_s;
    end
  end

`ifdef BEST_SCORE_EN
  logic [SEC_W-1:0] best_r;
  logic             new_best_r;

  // Best score latches only on a strictly better final score at game over.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_r     <= {SEC_W{1'b0}};
      new_best_r <= 1'b0;
    end else if ((state_r == RUNNING) && collision && (elapsed_nxt_s > best_r)) begin
      best_r     <= elapsed_nxt_s;
      new_best_r <= 1'b1;
    end else begin
      new_best_r <= 1'b0;
    end
  end

  assign best_sec = best_r;
  assign new_best = new_best_r;
`else
  assign best_sec = {SEC_W{1'b0}};
  assign new_best = 1'b0;
`endif

  assign state       = state_r;
  assign play_en     = play_en_r;
  assign sec_tick    = tick_s;
  assign countdown   = countdown_r;
  assign elapsed_sec = elapsed_r;

endmodule
